// File: rtl/ps2_scancode_decoder_if.sv
// ps2_scancode_decoder_if
//   Event-side handshake between the scancode decoder and its CPU-side reader.
//   master : decoder (drives the head event and overflow flag, samples evt_rd)
//   slave  : reader  (samples the head event, drives evt_rd)
//   evt_valid  FIFO non-empty, head event presented
//   evt_code   scancode of the head event
//   evt_ext    head event was E0-prefixed
//   evt_brk    head event is a key release
//   evt_rd     pop request for the head event
//   evt_ovf    sticky overflow flag
interface ps2_scancode_decoder_if;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_brk;
  logic       evt_rd;
  logic       evt_ovf;

  modport master (
    output evt_valid, evt_code, evt_ext, evt_brk, evt_ovf,
    input  evt_rd
  );

  modport slave (
    input  evt_valid, evt_code, evt_ext, evt_brk, evt_ovf,
    output evt_rd
  );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
//   Takes bytes from the PS/2 receive stage (byte + busy flag, PS/2 clock
//   domain), moves them into the clk domain, folds Set-2 prefix sequences
//   (E0 extended, F0 break, E1 pause) into single key events and queues the
//   events in a first-word-fall-through FIFO.
// Ports
//   clk       system clock
//   rst       asynchronous active-high reset
//   ps2_data  received byte, quasi-static while ps2_bsy is low
//   ps2_bsy   receive-stage busy flag, asynchronous to clk
//   evt       event handshake (master side), see ps2_scancode_decoder_if
//
// Decode FSM
//   state  | meaning
//   IDLE   | no prefix pending; data bytes become events directly
//   PREFIX | E0 and/or F0 seen; next data byte takes the collected flags
//   SKIP   | inside the 8-byte pause sequence; bytes are swallowed
module ps2_scancode_decoder #(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            ps2_data,
  input  logic                  ps2_bsy,
  ps2_scancode_decoder_if.master evt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

  // ---------------------------------------------------------------------
  // Busy synchroniser and falling-edge detect
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] bsy_sync;
  logic                   bsy_dly;
  logic                   bsy_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bsy_sync <= '1;
      bsy_dly  <= 1'b1;
    end else begin
      bsy_sync <= {bsy_sync[SYNC_STAGES-2:0], ps2_bsy};
      bsy_dly  <= bsy_sync[SYNC_STAGES-1];
    end
  end

  assign bsy_fall = bsy_dly & ~bsy_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // Settle timer: down-counter, byte is taken on terminal count.
  // ps2_data is sampled without synchronisation; it has been stable for a
  // long time by the point busy is seen low in this domain.
  // ---------------------------------------------------------------------
  logic          settle_act;
  logic [CW-1:0] settle_cnt;
  logic [7:0]    byte_reg;
  logic          byte_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_act <= 1'b0;
      settle_cnt <= '0;
      byte_reg   <= 8'h00;
      byte_vld   <= 1'b0;
    end else begin
      byte_vld <= 1'b0;
      if (bsy_fall) begin
        // a new edge restarts the wait; only one byte is ever taken
        settle_act <= 1'b1;
        settle_cnt <= CW'(SETTLE_CYCLES);
      end else if (settle_act) begin
        if (settle_cnt == '0) begin
          byte_reg   <= ps2_data;
          byte_vld   <= 1'b1;
          settle_act <= 1'b0;
        end else begin
          settle_cnt <= settle_cnt - CW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Byte classification
  // ---------------------------------------------------------------------
  logic is_status;
  logic is_e0;
  logic is_f0;
  logic is_e1;
  logic is_data;

  assign is_status = byte_reg inside {8'hFA, 8'hAA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
  assign is_e0     = (byte_reg == 8'hE0);
  assign is_f0     = (byte_reg == 8'hF0);
  assign is_e1     = (byte_reg == 8'hE1);
  assign is_data   = ~is_status & ~is_e0 & ~is_f0 & ~is_e1;

  // ---------------------------------------------------------------------
  // Decode FSM
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREFIX = 2'd1,
    SKIP   = 2'd2
  } state_t;

  state_t     state;
  logic       ext_f;
  logic       brk_f;
  logic [2:0] skip_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ext_f    <= 1'b0;
      brk_f    <= 1'b0;
      skip_cnt <= 3'd0;
    end else if (byte_vld) begin
      case (state)
        IDLE: begin
          if (is_e0) begin
            ext_f <= 1'b1;
            state <= PREFIX;
          end else if (is_f0) begin
            brk_f <= 1'b1;
            state <= PREFIX;
          end else if (is_e1) begin
            skip_cnt <= 3'd7;
            state    <= SKIP;
          end
        end
        PREFIX: begin
          if (is_f0 && !brk_f) begin
            brk_f <= 1'b1;
          end else if (is_e0 && !ext_f && !brk_f) begin
            ext_f <= 1'b1;
          end else if (!is_status) begin
            // either a data byte (event pushed below) or an out-of-order
            // prefix (sequence abandoned); both end the sequence
            ext_f <= 1'b0;
            brk_f <= 1'b0;
            state <= IDLE;
          end
        end
        SKIP: begin
          skip_cnt <= skip_cnt - 3'd1;
          if (skip_cnt == 3'd1) state <= IDLE;
        end
        default: begin
          ext_f <= 1'b0;
          brk_f <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Event generation is decoded from the current state and byte so the
  // push lands on the byte_vld cycle itself.
  logic       push_en;
  logic [9:0] push_word;

  assign push_en = byte_vld &
                   ((((state == IDLE) || (state == PREFIX)) & is_data) |
                    ((state == SKIP) & (skip_cnt == 3'd1)));

  assign push_word = (state == SKIP) ? {8'hE1, 2'b00} : {byte_reg, ext_f, brk_f};

  // ---------------------------------------------------------------------
  // Event FIFO (first-word fall-through)
  // ---------------------------------------------------------------------
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [9:0]  mem [FIFO_DEPTH];
  logic        empty;
  logic        full;
  logic        pop;
  logic        do_write;
  logic        ovf_q;
  logic [9:0]  head;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = evt.evt_rd & ~empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign do_write = push_en & (~full | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (do_write)                 wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)                      rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push_en && full && !pop)  ovf_q  <= 1'b1;
    end
  end

  // storage only; validity is carried by the pointers
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr[AW-1:0]] <= push_word;
  end

  assign head = mem[rd_ptr[AW-1:0]];

  assign evt.evt_valid = ~empty;
  assign evt.evt_code  = empty ? 8'h00 : head[9:2];
  assign evt.evt_ext   = empty ? 1'b0  : head[1];
  assign evt.evt_brk   = empty ? 1'b0  : head[0];
  assign evt.evt_ovf   = ovf_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder
//   Scoreboard bench: each byte sequence pushes its expected events into a
//   queue; a reader process pops the DUT FIFO and compares against the queue.
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ps2_data = 8'h00;
  logic       ps2_bsy = 1'b1;

  ps2_scancode_decoder_if evt_bus ();

  ps2_scancode_decoder #(
    .SYNC_STAGES   (2),
    .SETTLE_CYCLES (2),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_data (ps2_data),
    .ps2_bsy  (ps2_bsy),
    .evt      (evt_bus)
  );

  always #5 clk = ~clk;

  int         n_chk  = 0;
  int         n_pass = 0;
  logic [9:0] exp_q[$];
  logic       rd_auto = 1'b0;
  logic       rd_q    = 1'b0;
  logic       rd_man  = 1'b0;

  assign evt_bus.evt_rd = rd_auto ? rd_q : rd_man;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [9:0] ev(input logic [7:0] c, input logic e, input logic b);
    return {c, e, b};
  endfunction

  function automatic logic [9:0] head();
    return {evt_bus.evt_code, evt_bus.evt_ext, evt_bus.evt_brk};
  endfunction

  // reader: pops one event per cycle while enabled and checks it
  initial begin
    logic [9:0] exp_w;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_q = 1'b0;
      end else if (rd_auto && evt_bus.evt_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_evt", 32'(evt_bus.evt_valid), 32'd0);
        end else begin
          exp_w = exp_q.pop_front();
          chk("evt", 32'(head()), 32'(exp_w));
        end
        rd_q = 1'b1;
      end else begin
        rd_q = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    ps2_data = b;
    ps2_bsy  = 1'b0;
    repeat (50) @(negedge clk);
    ps2_bsy = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    rd_auto = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_empty"}, 32'(evt_bus.evt_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int         lat;
    logic [9:0] exp_w;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(evt_bus.evt_valid), 32'd0);
    chk("rst_code",  32'(evt_bus.evt_code),  32'd0);
    chk("rst_ext",   32'(evt_bus.evt_ext),   32'd0);
    chk("rst_brk",   32'(evt_bus.evt_brk),   32'd0);
    chk("rst_ovf",   32'(evt_bus.evt_ovf),   32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 1C with latency measurement, then F0 1C
    exp_q.push_back(ev(8'h1C, 1'b0, 1'b0));
    @(negedge clk);
    ps2_data = 8'h1C;
    ps2_bsy  = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (evt_bus.evt_valid && lat < 0) lat = i - 1;
    end
    chk("latency", 32'(lat), 32'd6);
    repeat (30) @(negedge clk);
    ps2_bsy = 1'b1;
    repeat (20) @(negedge clk);
    rd_auto = 1'b1;
    exp_q.push_back(ev(8'h1C, 1'b0, 1'b1));
    send_byte(8'hF0); send_byte(8'h1C);
    drain("make_break");

    // extended make/break and illegal prefix order
    exp_q.push_back(ev(8'h75, 1'b1, 1'b0));
    send_byte(8'hE0); send_byte(8'h75);
    exp_q.push_back(ev(8'h75, 1'b1, 1'b1));
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    exp_q.push_back(ev(8'h75, 1'b0, 1'b0));
    send_byte(8'hF0); send_byte(8'hE0); send_byte(8'h75);
    drain("extended");

    // pause sequence then a normal byte
    exp_q.push_back(ev(8'hE1, 1'b0, 1'b0));
    send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
    send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
    exp_q.push_back(ev(8'h1C, 1'b0, 1'b0));
    send_byte(8'h1C);
    drain("pause");

    // status bytes, including one inside a prefix
    exp_q.push_back(ev(8'h6B, 1'b1, 1'b0));
    send_byte(8'hAA); send_byte(8'hFA);
    send_byte(8'hE0); send_byte(8'hFA); send_byte(8'h6B);
    drain("status");

    // overflow
    rd_auto = 1'b0;
    chk("ovf_before", 32'(evt_bus.evt_ovf), 32'd0);
    exp_q.push_back(ev(8'h1C, 1'b0, 1'b0));
    exp_q.push_back(ev(8'h32, 1'b0, 1'b0));
    exp_q.push_back(ev(8'h21, 1'b0, 1'b0));
    exp_q.push_back(ev(8'h23, 1'b0, 1'b0));
    send_byte(8'h1C); send_byte(8'h32); send_byte(8'h21); send_byte(8'h23);
    chk("ovf_at_full", 32'(evt_bus.evt_ovf), 32'd0);
    send_byte(8'h24);
    chk("ovf_set",   32'(evt_bus.evt_ovf),   32'd1);
    chk("ovf_valid", 32'(evt_bus.evt_valid), 32'd1);
    drain("ovf_drain");
    chk("ovf_sticky", 32'(evt_bus.evt_ovf), 32'd1);

    // refill, then push coincident with pop while full
    rd_auto = 1'b0;
    exp_q.push_back(ev(8'h15, 1'b0, 1'b0));
    exp_q.push_back(ev(8'h1D, 1'b0, 1'b0));
    exp_q.push_back(ev(8'h24, 1'b0, 1'b0));
    exp_q.push_back(ev(8'h2D, 1'b0, 1'b0));
    send_byte(8'h15); send_byte(8'h1D); send_byte(8'h24); send_byte(8'h2D);
    @(negedge clk);
    ps2_data = 8'h2B;
    ps2_bsy  = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    exp_w = exp_q.pop_front();
    chk("coinc_head", 32'(head()), 32'(exp_w));
    rd_man = 1'b1;
    exp_q.push_back(ev(8'h2B, 1'b0, 1'b0));
    @(posedge clk);
    #1 rd_man = 1'b0;
    repeat (44) @(negedge clk);
    ps2_bsy = 1'b1;
    repeat (20) @(negedge clk);
    drain("coinc");

    // reset mid-prefix with events queued
    rd_auto = 1'b0;
    send_byte(8'h1C); send_byte(8'h32);
    chk("pre_rst_valid", 32'(evt_bus.evt_valid), 32'd1);
    send_byte(8'hE0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(evt_bus.evt_valid), 32'd0);
    chk("mid_rst_code",  32'(evt_bus.evt_code),  32'd0);
    chk("mid_rst_ext",   32'(evt_bus.evt_ext),   32'd0);
    chk("mid_rst_brk",   32'(evt_bus.evt_brk),   32'd0);
    chk("mid_rst_ovf",   32'(evt_bus.evt_ovf),   32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.push_back(ev(8'h1C, 1'b0, 1'b0));
    send_byte(8'h1C);
    drain("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Consumes bytes from the PS/2 receive stage: a parallel byte plus a busy flag, in the PS/2 clock domain.
- Brings the byte into the system clock domain.
- Decodes Set-2 prefix sequences (E0 extended, F0 break, E1 pause) into single key events.
- Buffers those events in a small first-word-fall-through FIFO for the CPU-side reader.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on ps2_bsy; legal values 2..3.
- SETTLE_CYCLES, 2, clk cycles between the detected busy falling edge and the ps2_data sample.
- FIFO_DEPTH, 4, event FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- ps2_data  in  8  received byte from the receive stage; quasi-static while ps2_bsy is low.
- ps2_bsy  in  1  receive-stage busy flag, asynchronous to clk; a low level means ps2_data is valid.
- evt_valid  out  1  FIFO non-empty; head event is presented on evt_code, evt_ext and evt_brk.
- evt_code  out  8  scancode of the head event.
- evt_ext  out  1  head event was E0-prefixed.
- evt_brk  out  1  head event is a key release (F0-prefixed).
- evt_rd  in  1  pops the head event when evt_valid=1; ignored when the FIFO is empty.
- evt_ovf  out  1  sticky flag: an event was dropped because the FIFO was full.

Behaviour:
- Reset (async assert, sync release):
  - sync chain loads 1 (idle busy).
  - FSM goes to IDLE; prefix flags and skip counter clear.
  - FIFO empties.
  - All outputs 0: evt_valid=0, evt_code=0, evt_ext=0, evt_brk=0, evt_ovf=0.
  - Reset mid-sequence discards partial prefixes and any pending capture.
- Capture path:
  - ps2_bsy passes through SYNC_STAGES flops; a falling edge is detected on the synced value.
  - After the edge, a counter waits SETTLE_CYCLES clk cycles, then latches ps2_data into byte_reg and pulses byte_vld for 1 cycle.
  - A second falling edge while the counter is still running restarts it; only one byte is taken.
  - ps2_data is not synchronised; it is stable for a full PS/2 clock period while busy is low.
- Decode FSM, evaluated on byte_vld:
  - IDLE:
    - FA, AA, FE, EE, 00, FF are status/error bytes: discard, no event, stay in IDLE.
    - E0: set ext, go to PREFIX.
    - F0: set brk, go to PREFIX.
    - E1: go to SKIP with skip_cnt=7.
    - Any other byte: push {byte, ext=0, brk=0}, stay in IDLE.
  - PREFIX:
    - F0 with brk=0: set brk, stay in PREFIX.
    - E0 with ext=0 and brk=0: set ext, stay in PREFIX.
    - Any other E0/F0/E1 (illegal order or repeated prefix): clear flags, go to IDLE, no event.
    - Status bytes: discard; prefix state is kept.
    - Any other byte: push {byte, ext, brk}, clear flags, go to IDLE.
  - SKIP:
    - Each byte decrements skip_cnt.
    - When the count reaches 0: push {E1, 0, 0}, go to IDLE.
    - Pause therefore produces exactly one event.
- Latency: an event pushed on the byte_vld cycle is visible on evt_valid the next cycle. From the first clk edge sampling ps2_bsy=0 to evt_valid=1 is SYNC_STAGES+SETTLE_CYCLES+2 cycles when the FIFO was empty.
- FIFO:
  - log2(FIFO_DEPTH)+1-bit read and write pointers; full/empty are taken from the MSB compare, with wrap-around.
  - Outputs are driven combinationally from the head entry. When empty, evt_code, evt_ext and evt_brk read 0.
  - Push when full without a pop: event dropped, evt_ovf set to 1 and held until reset.
  - Push and pop on the same cycle when full: both succeed, no drop, evt_ovf unchanged.
  - Push and pop on the same cycle when empty: the push is stored and the pop is ignored (evt_valid was 0).
  - evt_rd held high drains one entry per cycle.

Test Plan:
- Reset, then bytes 1C then F0 1C, with each byte presented by driving ps2_bsy low for 50 clk -> two events {1C,0,0} then {1C,0,1}. Check latency of 6 cycles from the bsy low sample to evt_valid.
- E0 75, then E0 F0 75 -> {75,1,0} then {75,1,1}. Then F0 E0 75 -> no event for the prefix pair, {75,0,0} for the trailing byte.
- Pause sequence E1 14 77 E1 F0 14 F0 77 -> exactly one event {E1,0,0}. Then byte 1C -> {1C,0,0}.
- AA, FA, E0 FA 6B -> only {6B,1,0} emitted.
- Push 5 bytes (1C, 32, 21, 23, 24) with evt_rd=0 and FIFO_DEPTH=4 -> evt_ovf=1; drain returns 1C, 32, 21, 23. With the FIFO full, a push coincident with evt_rd -> no additional drop.
- Assert rst while in PREFIX (after E0) with 2 events queued -> all outputs 0 immediately. After release, byte 1C -> {1C,0,0} (ext not carried over).
